// File: rtl/vn_control_unit.sv
// vn_control_unit
// Multi-cycle fetch/decode/execute sequencer for the 4-bit Von Neumann
// processor. Owns the program counter, accumulator, instruction register and
// latched flags. Instructions and data share one 16-word memory. A synchronous
// external ALU is driven here and its latency is waited out.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            leave IDLE and begin execution (sampled in IDLE only)
//   mem_addr         shared memory address
//   mem_wdata        store data, {4'h0, acc}
//   mem_we           write strobe, one cycle per STA
//   mem_rdata        read data for the address presented in the previous cycle
//   alu_a, alu_b     ALU operands
//   alu_cs           ALU control select, 5'b00000 = NOP/hold
//   alu_res          ALU result, valid one cycle after alu_cs
//   alu_flags        ALU flags {V,Z,S,C}, valid two cycles after alu_cs
//   acc, pc          accumulator and program counter
//   zf, cf, sf, vf   latched flags
//   instr_done       one-cycle pulse in the last state of each instruction
//   halted           high while in HALT
module vn_control_unit #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [4:0] alu_cs,
  input  logic [3:0] alu_res,
  input  logic [3:0] alu_flags,
  output logic [3:0] acc,
  output logic [3:0] pc,
  output logic       zf,
  output logic       cf,
  output logic       sf,
  output logic       vf,
  output logic       instr_done,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPRD,
    S_EXEC,
    S_ALU_WAIT,
    S_FLAGS,
    S_STORE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_LDA  = 4'h7;
  localparam logic [3:0] OP_STA  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [4:0] CS_HOLD = 5'b00000;
  localparam logic [4:0] CS_ADD  = 5'b00001;
  localparam logic [4:0] CS_AND  = 5'b00010;
  localparam logic [4:0] CS_OR   = 5'b00011;
  localparam logic [4:0] CS_XOR  = 5'b00100;
  localparam logic [4:0] CS_NOT  = 5'b00101;
  localparam logic [4:0] CS_SHL  = 5'b00110;
  localparam logic [4:0] CS_PASS = 5'b00111;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] acc_q, acc_d;
  logic [7:0] ir_q, ir_d;
  logic       zf_q, zf_d;
  logic       cf_q, cf_d;
  logic       sf_q, sf_d;
  logic       vf_q, vf_d;

  logic [3:0] dec_op;
  logic [3:0] dec_operand;
  logic [3:0] ir_op;
  logic [3:0] pc_inc;

  // In DECODE the instruction is still on mem_rdata; ir only holds it from
  // the following cycle onward.
  assign dec_op      = mem_rdata[7:4];
  assign dec_operand = mem_rdata[3:0];
  assign ir_op       = ir_q[7:4];
  assign pc_inc      = pc_q + 4'd1;

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      acc_q   <= 4'h0;
      ir_q    <= 8'h00;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      sf_q    <= 1'b0;
      vf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      sf_q    <= sf_d;
      vf_q    <= vf_d;
    end
  end

  // Next-state and output decode. All strobes come straight from state_q so
  // an asynchronous reset drops them in the same cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    ir_d       = ir_q;
    zf_d       = zf_q;
    cf_d       = cf_q;
    sf_d       = sf_q;
    vf_d       = vf_q;
    mem_addr   = pc_q;
    mem_we     = 1'b0;
    alu_cs     = CS_HOLD;
    alu_a      = acc_q;
    alu_b      = 4'h0;
    instr_done = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        ir_d = mem_rdata;
        pc_d = pc_inc;
        case (dec_op)
          OP_ADD, OP_AND, OP_OR, OP_XOR, OP_LDA: state_d = S_OPRD;
          OP_NOT, OP_SHL, OP_LDI:                state_d = S_EXEC;
          OP_STA:                                state_d = S_STORE;
          OP_HALT:                               state_d = S_HALT;
          OP_JMP: begin
            pc_d       = dec_operand;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JZ: begin
            if (zf_q) pc_d = dec_operand;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JC: begin
            if (cf_q) pc_d = dec_operand;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          // NOP and the unassigned opcodes D/E
          default: begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_OPRD: begin
        mem_addr = ir_q[3:0];
        state_d  = S_EXEC;
      end

      // Operand fetched in OPRD is on mem_rdata now.
      S_EXEC: begin
        case (ir_op)
          OP_ADD: begin alu_cs = CS_ADD; alu_b = mem_rdata[3:0]; end
          OP_AND: begin alu_cs = CS_AND; alu_b = mem_rdata[3:0]; end
          OP_OR:  begin alu_cs = CS_OR;  alu_b = mem_rdata[3:0]; end
          OP_XOR: begin alu_cs = CS_XOR; alu_b = mem_rdata[3:0]; end
          OP_NOT: alu_cs = CS_NOT;
          OP_SHL: alu_cs = CS_SHL;
          OP_LDA: begin alu_cs = CS_PASS; alu_a = mem_rdata[3:0]; end
          OP_LDI: begin alu_cs = CS_PASS; alu_a = ir_q[3:0]; end
          default: alu_cs = CS_HOLD;
        endcase
        state_d = S_ALU_WAIT;
      end

      S_ALU_WAIT: begin
        acc_d   = alu_res;
        state_d = S_FLAGS;
      end

      // Loads only pass a value through, so carry and overflow are kept.
      S_FLAGS: begin
        zf_d = alu_flags[2];
        sf_d = alu_flags[1];
        if (ir_op != OP_LDA && ir_op != OP_LDI) begin
          vf_d = alu_flags[3];
          cf_d = alu_flags[0];
        end
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_STORE: begin
        mem_we     = 1'b1;
        mem_addr   = ir_q[3:0];
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_wdata = {4'h0, acc_q};
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign sf        = sf_q;
  assign vf        = vf_q;

endmodule

// File: tb/tb_vn_control_unit.sv
// tb_vn_control_unit
// Self-checking bench for vn_control_unit. Provides a 16x8 synchronous memory
// and a model of the synchronous 4-bit ALU (1-cycle result, 2-cycle flags).
// Two-instruction programs come from a vector table; multi-cycle corner
// cases (reset, jumps, store, self-modifying code, wrap and halt) are
// hand-written sequences.
module tb_vn_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata = 8'h00;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_cs;
  logic [3:0] alu_res = 4'h0;
  logic [3:0] alu_flags = 4'h0;
  logic [3:0] acc;
  logic [3:0] pc;
  logic       zf, cf, sf, vf;
  logic       instr_done;
  logic       halted;

  logic [3:0] alu_fl1 = 4'h0;
  logic [7:0] mem  [16];
  logic [7:0] prog [16];
  logic [3:0] flagsObs;

  int passCount  = 0;
  int totalCount = 0;

  typedef struct {
    logic [3:0] init;
    logic [7:0] instr;
    logic [7:0] data;
    logic [3:0] expAcc;
    logic [3:0] expFlags;
    int         expCycles;
  } vec_t;

  vec_t vecs[12];

  vn_control_unit #(.RESET_PC(4'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cs     (alu_cs),
    .alu_res    (alu_res),
    .alu_flags  (alu_flags),
    .acc        (acc),
    .pc         (pc),
    .zf         (zf),
    .cf         (cf),
    .sf         (sf),
    .vf         (vf),
    .instr_done (instr_done),
    .halted     (halted)
  );

  assign flagsObs = {vf, zf, sf, cf};

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Shared memory: reloaded from prog while reset is held, otherwise written
  // by the DUT; read data appears one cycle after the address.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= prog[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Reference 4-bit ALU behaviour; returns {V,Z,S,C,result}.
  function automatic logic [7:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                          input logic [4:0] cs);
    logic [4:0] sum;
    logic [3:0] r;
    logic       c, v;
    sum = 5'd0;
    c = 1'b0;
    v = 1'b0;
    r = a;
    case (cs)
      5'd1: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[3:0];
        c   = sum[4];
        v   = (a[3] == b[3]) && (r[3] != a[3]);
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = ~a;
      5'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
      default: r = a;
    endcase
    return {v, (r == 4'h0), r[3], c, r};
  endfunction

  // Synchronous ALU: result registered one cycle after a nonzero select,
  // flags pass through one more register stage; select 0 holds everything.
  always @(posedge clk) begin
    logic [7:0] o;
    o = aluModel(alu_a, alu_b, alu_cs);
    if (alu_cs != 5'd0) begin
      alu_res <= o[3:0];
      alu_fl1 <= o[7:4];
    end
    alu_flags <= alu_fl1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic noteTimeout(input string name);
    totalCount++;
    $display("[TB] FAIL timeout_%s: event not seen within 64 cycles", name);
  endtask

  // kind: 0 instr_done, 1 nonzero alu_cs, 2 mem_we, 3 halted
  task automatic waitEvent(input int kind, input string name, output int cycles);
    bit hit;
    hit = 1'b0;
    cycles = 0;
    for (int k = 0; k < 64 && !hit; k++) begin
      @(negedge clk);
      cycles++;
      case (kind)
        0:       hit = instr_done;
        1:       hit = (alu_cs != 5'd0);
        2:       hit = mem_we;
        default: hit = halted;
      endcase
    end
    if (!hit) noteTimeout(name);
  endtask

  task automatic clearProg();
    for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
  endtask

  // Leaves the DUT in FETCH at a falling edge.
  task automatic resetAndStart();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    int c;
    clearProg();
    prog[0]  = {4'h9, vecs[idx].init};
    prog[1]  = vecs[idx].instr;
    prog[14] = vecs[idx].data;
    resetAndStart();
    waitEvent(0, $sformatf("vec%0d_ldi", idx), c);
    waitEvent(0, $sformatf("vec%0d_op", idx), c);
    checkOutput($sformatf("vec%0d_cycles", idx), c, vecs[idx].expCycles);
    @(negedge clk);
    checkOutput($sformatf("vec%0d_acc", idx), acc, vecs[idx].expAcc);
    checkOutput($sformatf("vec%0d_flags", idx), flagsObs, vecs[idx].expFlags);
    checkOutput($sformatf("vec%0d_pc", idx), pc, 2);
  endtask

  initial begin
    int c;
    int bad;
    int weCycles;
    logic [3:0] weAddr;
    logic [7:0] weData;

    rst = 1'b1;
    start = 1'b0;
    clearProg();

    //              init   instr  data   acc    {V,Z,S,C} cycles
    vecs[0]  = '{4'h5, 8'h1E, 8'h0C, 4'h1, 4'b0001, 6};
    vecs[1]  = '{4'h7, 8'h1E, 8'h01, 4'h8, 4'b1010, 6};
    vecs[2]  = '{4'hF, 8'h2E, 8'h00, 4'h0, 4'b0100, 6};
    vecs[3]  = '{4'hA, 8'h3E, 8'h05, 4'hF, 4'b0010, 6};
    vecs[4]  = '{4'h6, 8'h4E, 8'h06, 4'h0, 4'b0100, 6};
    vecs[5]  = '{4'h5, 8'h50, 8'h00, 4'hA, 4'b0010, 5};
    vecs[6]  = '{4'h9, 8'h60, 8'h00, 4'h2, 4'b0001, 5};
    vecs[7]  = '{4'h3, 8'h7E, 8'h0C, 4'hC, 4'b0010, 6};
    vecs[8]  = '{4'h4, 8'h98, 8'h00, 4'h8, 4'b0010, 5};
    vecs[9]  = '{4'h3, 8'h00, 8'h00, 4'h3, 4'b0000, 2};
    vecs[10] = '{4'h3, 8'hD0, 8'h00, 4'h3, 4'b0000, 2};
    vecs[11] = '{4'h8, 8'h1E, 8'h08, 4'h0, 4'b1101, 6};

    for (int i = 0; i < 12; i++) applyStimulus(i);

    // Reset in the middle of ADD's EXEC, then idle with start low.
    clearProg();
    prog[0] = 8'h95; prog[1] = 8'h1E; prog[14] = 8'h0C;
    resetAndStart();
    waitEvent(0, "rst_ldi", c);
    waitEvent(1, "rst_exec", c);
    checkOutput("exec_cs", alu_cs, 5'b00001);
    checkOutput("exec_a", alu_a, 4'h5);
    checkOutput("exec_b", alu_b, 4'hC);
    rst = 1'b1;
    #1;
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_acc", acc, 0);
    checkOutput("rst_flags", flagsObs, 0);
    checkOutput("rst_cs", alu_cs, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_done", instr_done, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_addr != 4'h0 || alu_cs != 5'd0 || mem_we || instr_done || halted) bad++;
    end
    checkOutput("idle_bad_cycles", bad, 0);
    checkOutput("idle_pc", pc, 0);

    // Reset while the store strobe is high drops it at once.
    clearProg();
    prog[0] = 8'h90; prog[1] = 8'h83;
    resetAndStart();
    waitEvent(2, "rst_store", c);
    checkOutput("store_addr_pre_rst", mem_addr, 3);
    rst = 1'b1;
    #1;
    checkOutput("rst_store_we", mem_we, 0);
    @(negedge clk);
    rst = 1'b0;

    // Conditional and unconditional jumps.
    clearProg();
    prog[0] = 8'h9F; prog[1] = 8'h2C; prog[2] = 8'hB9; prog[12] = 8'h00;
    prog[9] = 8'hC3; prog[10] = 8'hA4;
    resetAndStart();
    waitEvent(0, "j_ldi", c);
    waitEvent(0, "j_and", c);
    @(negedge clk);
    checkOutput("j_and_acc", acc, 0);
    checkOutput("j_and_flags", flagsObs, 4'b0100);
    waitEvent(0, "j_jz", c);
    checkOutput("jz_cycles", c + 1, 2);
    @(negedge clk);
    checkOutput("jz_pc", pc, 9);
    waitEvent(0, "j_jc", c);
    @(negedge clk);
    checkOutput("jc_not_taken_pc", pc, 10);
    waitEvent(0, "j_jmp", c);
    @(negedge clk);
    checkOutput("jmp_pc", pc, 4);
    waitEvent(3, "j_halt", c);
    checkOutput("j_halt_pc", pc, 5);

    // Shift, store, then a load that must keep the carry for JC.
    clearProg();
    prog[0] = 8'h99; prog[1] = 8'h60; prog[2] = 8'h8F; prog[3] = 8'h90; prog[4] = 8'hC7;
    resetAndStart();
    waitEvent(0, "s_ldi", c);
    waitEvent(0, "s_shl", c);
    @(negedge clk);
    checkOutput("shl_acc", acc, 2);
    checkOutput("shl_flags", flagsObs, 4'b0001);
    weCycles = 0;
    weAddr = 4'h0;
    weData = 8'h00;
    c = 0;
    bad = 1;
    for (int k = 0; k < 10 && bad != 0; k++) begin
      @(negedge clk);
      c++;
      if (mem_we) begin
        weCycles++;
        weAddr = mem_addr;
        weData = mem_wdata;
      end
      if (instr_done) bad = 0;
    end
    if (bad != 0) noteTimeout("sta");
    checkOutput("sta_cycles", c + 1, 3);
    checkOutput("sta_we_cycles", weCycles, 1);
    checkOutput("sta_addr", weAddr, 15);
    checkOutput("sta_wdata", weData, 8'h02);
    @(negedge clk);
    checkOutput("sta_flags", flagsObs, 4'b0001);
    checkOutput("sta_mem15", mem[15], 8'h02);
    waitEvent(0, "s_ldi0", c);
    @(negedge clk);
    checkOutput("ldi_keeps_cf_flags", flagsObs, 4'b0101);
    waitEvent(0, "s_jc", c);
    @(negedge clk);
    checkOutput("jc_taken_pc", pc, 7);

    // Store into the very next instruction word replaces HALT with NOP.
    clearProg();
    prog[0] = 8'h90; prog[1] = 8'h82;
    resetAndStart();
    waitEvent(3, "smc_halt", c);
    checkOutput("smc_halt_pc", pc, 4);

    // PC wraps from 15 to 0.
    clearProg();
    prog[0] = 8'hAF; prog[15] = 8'h00;
    resetAndStart();
    waitEvent(0, "w_jmp", c);
    @(negedge clk);
    checkOutput("wrap_jmp_pc", pc, 15);
    waitEvent(0, "w_nop", c);
    @(negedge clk);
    checkOutput("wrap_pc", pc, 0);

    // HALT freezes everything and ignores start until reset.
    clearProg();
    resetAndStart();
    waitEvent(3, "h_halt", c);
    checkOutput("halt_pc", pc, 1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = (k % 2 == 0);
      if (pc != 4'h1 || !halted || instr_done || mem_we) bad++;
    end
    start = 1'b0;
    checkOutput("halt_frozen_bad_cycles", bad, 0);
    rst = 1'b1;
    #1;
    checkOutput("halt_rst_halted", halted, 0);
    checkOutput("halt_rst_pc", pc, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("halt_rst_idle", halted, 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
